sr_cmd_gen: RTL and testbench
=============================

Name: sr_cmd_gen

Overview:
Upstream command stage for the gated SR latch. It synchronises and debounces two raw asynchronous request lines (set, reset) and converts each debounced rising edge into a safe latch write: s/r set up, gate pulse, s/r hold. It guarantees s=r=1 is never driven; simultaneous requests are flagged, not forwarded. Its outputs s, r, clock_pulse connect directly to the latch's s, r, clock_pulse inputs.

Parameters:
DEB_CYCLES, 4, consecutive stable cycles required before the debounced level changes (>=1)
PULSE_W, 2, clock_pulse high width in clk cycles (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
set_raw  input  1  asynchronous set request level
reset_raw  input  1  asynchronous reset request level
s  output  1  latch set input, registered
r  output  1  latch reset input, registered
clock_pulse  output  1  latch gate enable, registered
busy  output  1  high whenever FSM not IDLE, registered
conflict  output  1  one-cycle pulse: simultaneous set+reset request dropped

Behaviour:
- Reset (already decided): one clock clk; reset rst_n is synchronous, active-low. On any edge with rst_n=0: s=r=clock_pulse=busy=conflict=0, FSM=IDLE, sync flops=0, debounced levels=0, counters=0, pending flags=0. Reset mid-pulse: clock_pulse is 0 from that edge on.
- Per input: 2-flop synchroniser, then debounce. The counter increments while the synced value differs from the debounced level. It clears when they match. The debounced level toggles, and the counter clears, when the count reaches DEB_CYCLES.
- req = debounced rising edge (1 cycle). Falling edges generate nothing.
- Raw held high through reset produces a request after release plus debounce.
- Latency: raw high before edge 0 -> s/r high after edge DEB_CYCLES+2 (SETUP) -> clock_pulse high after edge DEB_CYCLES+3.
- FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE: s=r=cp=0.
  - Exactly one of set_req/pend_set or reset_req/pend_reset -> SETUP, drive s=1,r=0 (set) or s=0,r=1 (reset).
  - Both -> conflict=1 for one cycle, clear pendings, stay IDLE, s=r=0.
- SETUP: 1 cycle, cp=0, s/r held -> PULSE.
- PULSE: cp=1 for exactly PULSE_W cycles, s/r held -> HOLD.
- HOLD: 1 cycle, cp=0, s/r held -> IDLE, where s=r=0.
- Total busy = PULSE_W+2 cycles per command.
- Requests arriving while busy set a pending flag per direction, one deep. A repeat of the same direction is absorbed. Pendings are serviced on the IDLE cycle after HOLD; set and reset both pending follow the conflict rule.
- A request arriving in the same cycle as return to IDLE is treated as pending (combined with the pending flags).
- Invariants: s&r never 1; cp=1 implies exactly one of s,r=1; s/r never change while cp=1.

Decomposition:
- Package sr_cmd_pkg:
  - state enum st_e {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD}
  - cmd enum cmd_e {CMD_NONE, CMD_SET, CMD_RESET}
  - function clog2-based counter width helper
- Sub-module sr_debounce (params DEB_CYCLES; ports clk, rst_n, raw, level, rise), instantiated twice. The FSM and pending logic stay in sr_cmd_gen.

Test Plan:
- DEB=4, PULSE_W=2; set_raw 0->1 held -> s=1 after 6 edges, clock_pulse=1 for edges 7-8, s=0 after edge 10; r=0 throughout; latched q=1.
- set_raw glitch high 3 cycles then low -> no debounced change; s, r, clock_pulse stay 0.
- set_raw and reset_raw rise same cycle -> conflict=1 for one cycle, s=r=clock_pulse=0, busy=0.
- reset request while a set command is in PULSE -> set completes, then one IDLE cycle, then reset SETUP; r=1, cp high 2 cycles; q=0.
- rst_n=0 during PULSE -> clock_pulse=0 and busy=0 from that edge; no pending served after release.
- Random raw toggling for 2000 cycles -> assertions for s&r never 1, cp implies s^r, and s/r stable during cp all hold.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// Shared types and helpers for the SR latch command generator.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } st_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_SET,
    CMD_RESET
  } cmd_e;

  // Width of a counter that must hold values up to max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser plus counter debouncer with a one-cycle rising-edge pulse.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = cnt_width(DEB_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;

  // Synchronise, then flip the level after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        // This sample is the DEB_CYCLES-th in a row that differs.
        level_q <= ~level_q;
        rise_q  <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns debounced set/reset requests into safe gated-SR-latch write sequences.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned PULSE_W    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_raw,
  input  logic reset_raw,
  output logic s,
  output logic r,
  output logic clock_pulse,
  output logic busy,
  output logic conflict
);

  localparam int unsigned PW = cnt_width(PULSE_W);

  logic set_level, set_rise, reset_level, reset_rise;
  logic set_req, reset_req;
  logic want_set, want_reset;

  st_e           state_q, state_d;
  cmd_e          cmd_q, cmd_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          pend_set_q, pend_set_d;
  logic          pend_reset_q, pend_reset_d;
  logic          s_q, s_d, r_q, r_d, cp_q, cp_d, busy_q, busy_d, conflict_q, conflict_d;

  sr_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_set (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (set_raw),
    .level(set_level),
    .rise (set_rise)
  );

  sr_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_reset (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (reset_raw),
    .level(reset_level),
    .rise (reset_rise)
  );

  // A rise always coincides with the new high level; qualifying keeps requests level-true.
  assign set_req   = set_rise & set_level;
  assign reset_req = reset_rise & reset_level;

  assign want_set   = set_req | pend_set_q;
  assign want_reset = reset_req | pend_reset_q;

  // Next-state, pending capture and registered-output precompute.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    pcnt_d       = pcnt_q;
    pend_set_d   = pend_set_q | set_req;
    pend_reset_d = pend_reset_q | reset_req;
    conflict_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Pendings and fresh requests are consumed together here.
        pend_set_d   = 1'b0;
        pend_reset_d = 1'b0;
        cmd_d        = CMD_NONE;
        if (want_set && want_reset) begin
          conflict_d = 1'b1;
        end else if (want_set) begin
          state_d = ST_SETUP;
          cmd_d   = CMD_SET;
        end else if (want_reset) begin
          state_d = ST_SETUP;
          cmd_d   = CMD_RESET;
        end
      end
      ST_SETUP: begin
        state_d = ST_PULSE;
        pcnt_d  = '0;
      end
      ST_PULSE: begin
        if (pcnt_q == PW'(PULSE_W - 1)) begin
          state_d = ST_HOLD;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    s_d    = busy_d && (cmd_d == CMD_SET);
    r_d    = busy_d && (cmd_d == CMD_RESET);
    cp_d   = (state_d == ST_PULSE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cmd_q        <= CMD_NONE;
      pcnt_q       <= '0;
      pend_set_q   <= 1'b0;
      pend_reset_q <= 1'b0;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      cp_q         <= 1'b0;
      busy_q       <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      pcnt_q       <= pcnt_d;
      pend_set_q   <= pend_set_d;
      pend_reset_q <= pend_reset_d;
      s_q          <= s_d;
      r_q          <= r_d;
      cp_q         <= cp_d;
      busy_q       <= busy_d;
      conflict_q   <= conflict_d;
    end
  end

  assign s           = s_q;
  assign r           = r_q;
  assign clock_pulse = cp_q;
  assign busy        = busy_q;
  assign conflict    = conflict_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen with a command scoreboard and a latch model.
module tb_sr_cmd_gen;

  localparam int unsigned DEB = 4;
  localparam int unsigned PW  = 2;
  // Edge index (from the raw rise) after which s/r first go high.
  localparam int T0 = DEB + 2;
  // Setup edge of a second command queued during the first one's pulse.
  localparam int T1 = T0 + PW + 3;

  localparam int EXP_SET   = 1;
  localparam int EXP_RESET = 2;
  localparam int EXP_CONF  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_raw = 1'b0;
  logic reset_raw = 1'b0;
  logic s, r, clock_pulse, busy, conflict;

  int n_cmp = 0;
  int n_fail = 0;
  int sb[$];
  bit sb_on = 1'b1;
  logic q_model = 1'b0;
  logic cp_prev = 1'b0;
  logic s_prev = 1'b0;
  logic r_prev = 1'b0;
  int mon_exp, mon_got;

  sr_cmd_gen #(
    .DEB_CYCLES(DEB),
    .PULSE_W   (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_raw    (set_raw),
    .reset_raw  (reset_raw),
    .s          (s),
    .r          (r),
    .clock_pulse(clock_pulse),
    .busy       (busy),
    .conflict   (conflict)
  );

  always #5 clk = ~clk;

  // Monitor: scoreboard pops, invariants and a gated SR latch model.
  always @(negedge clk) begin
    if (sb_on && clock_pulse && !cp_prev) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_cmd: unexpected pulse s=%0b r=%0b, nothing expected", s, r);
      end else begin
        mon_exp = sb.pop_front();
        mon_got = s ? EXP_SET : (r ? EXP_RESET : 0);
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_cmd: got cmd %0d want %0d", mon_got, mon_exp);
        end
      end
    end
    if (sb_on && conflict === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_conflict: unexpected conflict, nothing expected");
      end else begin
        mon_exp = sb.pop_front();
        if (mon_exp !== EXP_CONF) begin
          n_fail++;
          $display("FAIL sb_conflict: got conflict want cmd %0d", mon_exp);
        end
      end
    end
    n_cmp++;
    if ((s & r) === 1'b1) begin
      n_fail++;
      $display("FAIL inv_sr: s=%0b r=%0b both high", s, r);
    end else if (clock_pulse === 1'b1 && (s ^ r) !== 1'b1) begin
      n_fail++;
      $display("FAIL inv_cp: cp=1 with s=%0b r=%0b, want exactly one", s, r);
    end else if (clock_pulse && cp_prev && ({s, r} !== {s_prev, r_prev})) begin
      n_fail++;
      $display("FAIL inv_stable: s/r %b -> %b during cp", {s_prev, r_prev}, {s, r});
    end
    if (clock_pulse === 1'b1) q_model = s ? 1'b1 : (r ? 1'b0 : q_model);
    cp_prev = clock_pulse;
    s_prev  = s;
    r_prev  = r;
  end

  task automatic settle();
    set_raw   = 1'b0;
    reset_raw = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({s, r, clock_pulse, busy, conflict} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000", {s, r, clock_pulse, busy, conflict});
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if ({s, r, clock_pulse, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want 0000", {s, r, clock_pulse, busy});
    end
  endtask

  task automatic test_single_set();
    logic es, ecp;
    sb.push_back(EXP_SET);
    set_raw = 1'b1;
    for (int k = 0; k <= T0 + PW + 3; k++) begin
      @(negedge clk);
      es  = (k >= T0) && (k <= T0 + PW + 1);
      ecp = (k >= T0 + 1) && (k <= T0 + PW);
      n_cmp++;
      if ({s, r, clock_pulse, busy} !== {es, 1'b0, ecp, es}) begin
        n_fail++;
        $display("FAIL set_timing edge %0d: s,r,cp,busy=%b want %b", k,
                 {s, r, clock_pulse, busy}, {es, 1'b0, ecp, es});
      end
    end
    n_cmp++;
    if (q_model !== 1'b1) begin
      n_fail++;
      $display("FAIL set_latch_q: got %b want 1", q_model);
    end
    settle();
  endtask

  task automatic test_glitch();
    bit seen;
    seen = 1'b0;
    set_raw = 1'b1;
    repeat (3) @(negedge clk);
    set_raw = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if ((s | r | clock_pulse | busy) !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_quiet: got activity=1 want 0");
    end
    settle();
  endtask

  task automatic test_conflict();
    bit active;
    active = 1'b0;
    sb.push_back(EXP_CONF);
    set_raw   = 1'b1;
    reset_raw = 1'b1;
    for (int k = 0; k <= T0 + 6; k++) begin
      @(negedge clk);
      if ((s | r | clock_pulse | busy) !== 1'b0) active = 1'b1;
      n_cmp++;
      if (conflict !== (k == T0)) begin
        n_fail++;
        $display("FAIL conflict_pulse edge %0d: got %b want %b", k, conflict, (k == T0));
      end
    end
    n_cmp++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_no_cmd: got activity=1 want 0");
    end
    settle();
  endtask

  task automatic test_back_to_back();
    logic es, er, ecp;
    sb.push_back(EXP_SET);
    sb.push_back(EXP_RESET);
    set_raw = 1'b1;
    for (int k = 0; k <= T1 + PW + 3; k++) begin
      @(negedge clk);
      // Reset request debounces out while the set command is in its pulse.
      if (k == 1) reset_raw = 1'b1;
      es  = (k >= T0) && (k <= T0 + PW + 1);
      er  = (k >= T1) && (k <= T1 + PW + 1);
      ecp = ((k >= T0 + 1) && (k <= T0 + PW)) || ((k >= T1 + 1) && (k <= T1 + PW));
      n_cmp++;
      if ({s, r, clock_pulse, busy} !== {es, er, ecp, es | er}) begin
        n_fail++;
        $display("FAIL b2b_timing edge %0d: s,r,cp,busy=%b want %b", k,
                 {s, r, clock_pulse, busy}, {es, er, ecp, es | er});
      end
    end
    n_cmp++;
    if (q_model !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_latch_q: got %b want 0", q_model);
    end
    settle();
  endtask

  task automatic test_reset_mid_pulse();
    bit active;
    active = 1'b0;
    sb.push_back(EXP_SET);
    set_raw = 1'b1;
    for (int k = 0; k <= T0 + 1; k++) begin
      @(negedge clk);
      if (k == 1) reset_raw = 1'b1;
    end
    n_cmp++;
    if (clock_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_in_pulse: cp got %b want 1", clock_pulse);
    end
    rst_n     = 1'b0;
    set_raw   = 1'b0;
    reset_raw = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({s, r, clock_pulse, busy, conflict} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: got %b want 00000", {s, r, clock_pulse, busy, conflict});
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if ((busy | clock_pulse | conflict) !== 1'b0) active = 1'b1;
    end
    n_cmp++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_pending: got activity=1 want 0");
    end
  endtask

  task automatic test_held_through_reset();
    logic es, ecp;
    set_raw = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    sb.push_back(EXP_SET);
    rst_n = 1'b1;
    for (int k = 0; k <= T0 + PW + 3; k++) begin
      @(negedge clk);
      es  = (k >= T0) && (k <= T0 + PW + 1);
      ecp = (k >= T0 + 1) && (k <= T0 + PW);
      n_cmp++;
      if ({s, r, clock_pulse, busy} !== {es, 1'b0, ecp, es}) begin
        n_fail++;
        $display("FAIL held_rst edge %0d: s,r,cp,busy=%b want %b", k,
                 {s, r, clock_pulse, busy}, {es, 1'b0, ecp, es});
      end
    end
    settle();
  endtask

  task automatic test_random();
    int hold;
    hold  = 0;
    sb_on = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (hold == 0) begin
        set_raw   = 1'($urandom_range(0, 1));
        reset_raw = 1'($urandom_range(0, 1));
        hold      = $urandom_range(1, 12);
      end else begin
        hold--;
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_glitch();
    test_conflict();
    test_back_to_back();
    test_reset_mid_pulse();
    test_held_through_reset();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d commands outstanding want 0", sb.size());
    end
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
